// File: rtl/vga_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_game_pkg
// Description : Shared defaults, register map and display modes for the
//               VGA scoreboard game controller.
// Revision    : 1.0
// ============================================================================
package vga_game_pkg;

    localparam int c_DEF_NUM_PLAYERS = 2;
    localparam int c_DEF_SCORE_W     = 8;
    localparam int c_DEF_NUM_BUTTONS = 3;
    localparam int c_DEF_DEB_BITS    = 16;
    localparam int c_DEF_CLK_DIV     = 4;
    localparam int c_DEF_H_ACT       = 640;
    localparam int c_DEF_H_FP        = 16;
    localparam int c_DEF_H_SYNC      = 96;
    localparam int c_DEF_H_BP        = 48;
    localparam int c_DEF_V_ACT       = 480;
    localparam int c_DEF_V_FP        = 10;
    localparam int c_DEF_V_SYNC      = 2;
    localparam int c_DEF_V_BP        = 33;
    localparam int c_DEF_FLASH_BIT   = 4;

    localparam logic [11:0] c_OFF_BTN_LEVEL = 12'h000;
    localparam logic [11:0] c_OFF_BTN_EVENT = 12'h004;
    localparam logic [11:0] c_OFF_IRQ_EN    = 12'h008;
    localparam logic [11:0] c_OFF_CTRL      = 12'h00C;
    localparam logic [11:0] c_OFF_ACTIVE    = 12'h010;
    localparam logic [11:0] c_OFF_WINNER    = 12'h014;
    localparam logic [11:0] c_OFF_FRAME     = 12'h018;

    typedef enum logic [1:0] {
        MODE_SCORE  = 2'd0,
        MODE_WINNER = 2'd1,
        MODE_BLANK  = 2'd2
    } mode_e;

    function automatic int f_total(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    localparam int c_DEF_H_TOT = f_total(c_DEF_H_ACT, c_DEF_H_FP, c_DEF_H_SYNC, c_DEF_H_BP);
    localparam int c_DEF_V_TOT = f_total(c_DEF_V_ACT, c_DEF_V_FP, c_DEF_V_SYNC, c_DEF_V_BP);

endpackage
`default_nettype wire

// File: rtl/btn_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_sync
// Description : Two-flop synchroniser plus stability counter for one
//               active-low button; rise pulses on the released->pressed edge.
// Revision    : 1.0
// ============================================================================
module btn_debounce_sync #(
    parameter int DEB_BITS = 16
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic btn_n,
    output logic level,
    output logic rise
);

    logic [1:0]          r_sync;
    logic [DEB_BITS-1:0] r_cnt;
    logic                r_level;
    logic                w_synced;
    logic                w_flip;

    assign w_synced = r_sync[1];
    assign w_flip   = (w_synced != r_level) && (&r_cnt);

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], ~btn_n};
            if ((w_synced == r_level) || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
        end
    end

    assign level = r_level;
    assign rise  = w_flip & ~r_level;

endmodule
`default_nettype wire

// File: rtl/apb_vga_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_vga_game_ctrl
// Description : APB3 game-state registers, debounced buttons with IRQ, and
//               VGA timing/pixel coordinates for the scoreboard renderer.
// Revision    : 1.0
// ============================================================================
module apb_vga_game_ctrl
    import vga_game_pkg::*;
#(
    parameter int NUM_PLAYERS = c_DEF_NUM_PLAYERS,
    parameter int SCORE_W     = c_DEF_SCORE_W,
    parameter int NUM_BUTTONS = c_DEF_NUM_BUTTONS,
    parameter int DEB_BITS    = c_DEF_DEB_BITS,
    parameter int CLK_DIV     = c_DEF_CLK_DIV,
    parameter int H_ACT       = c_DEF_H_ACT,
    parameter int H_FP        = c_DEF_H_FP,
    parameter int H_SYNC      = c_DEF_H_SYNC,
    parameter int H_BP        = c_DEF_H_BP,
    parameter int V_ACT       = c_DEF_V_ACT,
    parameter int V_FP        = c_DEF_V_FP,
    parameter int V_SYNC      = c_DEF_V_SYNC,
    parameter int V_BP        = c_DEF_V_BP,
    parameter int FLASH_BIT   = c_DEF_FLASH_BIT
) (
    input  logic                           PCLK,
    input  logic                           PRESERN,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [31:0]                    PADDR,
    input  logic [31:0]                    PWDATA,
    output logic [31:0]                    PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_BUTTONS-1:0]         btn_n,
    output logic                           irq,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           pix_valid,
    output logic [9:0]                     pix_x,
    output logic [9:0]                     pix_y,
    output logic                           pix_ce,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_bus,
    output logic [2:0]                     active_player,
    output logic [3:0]                     winner,
    output logic [1:0]                     mode,
    output logic                           flash
);

    localparam int c_H_TOT = f_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOT = f_total(V_ACT, V_FP, V_SYNC, V_BP);
    localparam int c_HW    = $clog2(c_H_TOT);
    localparam int c_VW    = $clog2(c_V_TOT);
    localparam int c_DW    = $clog2(CLK_DIV);

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOT - 1);
    localparam logic [c_HW-1:0] c_H_ACT_W  = c_HW'(H_ACT);
    localparam logic [c_HW-1:0] c_HS_START = c_HW'(H_ACT + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOT - 1);
    localparam logic [c_VW-1:0] c_V_ACT_W  = c_VW'(V_ACT);
    localparam logic [c_VW-1:0] c_VS_START = c_VW'(V_ACT + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACT + V_FP + V_SYNC);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_rise;
    logic [NUM_BUTTONS-1:0] w_ev_clr;
    logic [NUM_BUTTONS-1:0] r_btn_event;
    logic [NUM_BUTTONS-1:0] r_irq_en;
    logic [1:0]             r_mode;
    logic [2:0]             r_active;
    logic [3:0]             r_winner;
    logic [SCORE_W-1:0]     r_score [NUM_PLAYERS];
    logic [SCORE_W-1:0]     w_score_rd;
    logic [15:0]            r_frame;
    logic [c_DW-1:0]        r_div;
    logic [c_HW-1:0]        r_h;
    logic [c_VW-1:0]        r_v;
    logic [11:0]            w_off;
    logic [5:0]             w_idx;
    logic                   w_is_score;
    logic                   w_mapped;
    logic                   w_ro;
    logic                   w_access;
    logic                   w_err;
    logic                   w_wr;
    logic                   w_unused_addr;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        btn_debounce_sync #(
            .DEB_BITS (DEB_BITS)
        ) u_deb (
            .PCLK    (PCLK),
            .PRESERN (PRESERN),
            .btn_n   (btn_n[g]),
            .level   (w_level[g]),
            .rise    (w_rise[g])
        );
    end

    assign w_off         = PADDR[11:0];
    assign w_idx         = PADDR[7:2];
    assign w_unused_addr = &{1'b0, PADDR[31:12]};

    always_comb begin
        w_is_score = (w_off[11:8] == 4'h1) && (w_off[1:0] == 2'b00) &&
                     (w_idx < 6'(NUM_PLAYERS));
        w_mapped   = w_is_score;
        w_ro       = 1'b0;
        case (w_off)
            c_OFF_BTN_LEVEL, c_OFF_FRAME: begin
                w_mapped = 1'b1;
                w_ro     = 1'b1;
            end
            c_OFF_BTN_EVENT, c_OFF_IRQ_EN, c_OFF_CTRL, c_OFF_ACTIVE, c_OFF_WINNER: begin
                w_mapped = 1'b1;
            end
            default: ;
        endcase
    end

    // Any rejected access leaves every register untouched.
    assign w_access = PSEL & PENABLE;
    assign w_err    = w_access & (~w_mapped | (PWRITE & (w_ro |
                      ((w_off == c_OFF_WINNER) && (PWDATA > 32'(NUM_PLAYERS))))));
    assign w_wr     = w_access & PWRITE & ~w_err;
    assign w_ev_clr = (w_wr && (w_off == c_OFF_BTN_EVENT)) ? PWDATA[NUM_BUTTONS-1:0] : '0;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_btn_event <= '0;
            r_irq_en    <= '0;
            r_mode      <= MODE_SCORE;
            r_active    <= 3'd0;
            r_winner    <= 4'd0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_score[i] <= '0;
            end
        end else begin
            // A press landing on the same edge as its W1C wins.
            r_btn_event <= (r_btn_event & ~w_ev_clr) | w_rise;
            if (w_wr) begin
                case (w_off)
                    c_OFF_IRQ_EN: r_irq_en <= PWDATA[NUM_BUTTONS-1:0];
                    c_OFF_CTRL:   r_mode   <= PWDATA[1:0];
                    c_OFF_ACTIVE: r_active <= 3'(PWDATA % 32'(NUM_PLAYERS));
                    c_OFF_WINNER: begin
                        r_winner <= PWDATA[3:0];
                        if ((PWDATA != 32'd0) && (r_mode == MODE_SCORE)) begin
                            r_mode <= MODE_WINNER;
                        end
                    end
                    default: ;
                endcase
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (w_is_score && (w_idx == 6'(i))) begin
                        r_score[i] <= PWDATA[SCORE_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        PRDATA     = '0;
        w_score_rd = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (w_is_score && (w_idx == 6'(i))) begin
                w_score_rd = r_score[i];
            end
        end
        if (PSEL && !PWRITE) begin
            case (w_off)
                c_OFF_BTN_LEVEL: PRDATA = 32'(w_level);
                c_OFF_BTN_EVENT: PRDATA = 32'(r_btn_event);
                c_OFF_IRQ_EN:    PRDATA = 32'(r_irq_en);
                c_OFF_CTRL:      PRDATA = 32'(r_mode);
                c_OFF_ACTIVE:    PRDATA = 32'(r_active);
                c_OFF_WINNER:    PRDATA = 32'(r_winner);
                c_OFF_FRAME:     PRDATA = 32'(r_frame);
                default:         PRDATA = w_is_score ? 32'(w_score_rd) : 32'd0;
            endcase
        end
    end

    assign pix_ce = (r_div == '0);

    // Sync/coordinate outputs capture the pre-increment counters, one pixel behind.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_div     <= '0;
            r_h       <= '0;
            r_v       <= '0;
            r_frame   <= 16'd0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
        end else begin
            r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            if (pix_ce) begin
                hsync     <= !((r_h >= c_HS_START) && (r_h < c_HS_END));
                vsync     <= !((r_v >= c_VS_START) && (r_v < c_VS_END));
                pix_valid <= (r_h < c_H_ACT_W) && (r_v < c_V_ACT_W) && (r_mode != MODE_BLANK);
                pix_x     <= 10'(r_h);
                pix_y     <= 10'(r_v);
                if (r_h == c_H_LAST) begin
                    r_h <= '0;
                    if (r_v == c_V_LAST) begin
                        r_v     <= '0;
                        r_frame <= r_frame + 16'd1;
                    end else begin
                        r_v <= r_v + 1'b1;
                    end
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
        assign score_bus[g*SCORE_W +: SCORE_W] = r_score[g];
    end

    assign PREADY        = 1'b1;
    assign PSLVERR       = w_err;
    assign irq           = |(r_btn_event & r_irq_en);
    assign active_player = r_active;
    assign winner        = r_winner;
    assign mode          = r_mode;
    assign flash         = r_frame[FLASH_BIT];

endmodule
`default_nettype wire
